aes_key_expansion: RTL and testbench
====================================

Name: aes_key_expansion

Overview:
- Iterative AES-128 key schedule.
- Accepts a 128-bit cipher key and streams round keys 0..10, one per handshake, to the round datapath downstream.
- Sits directly upstream of the existing round-constant generator: it drives that generator's 4-bit round number (1..10) and consumes its 32-bit rcon word.
- Each round key is derived from the previous one in a single cycle.

Parameters:
- KEY_W, 128, cipher/round key width in bits (fixed AES-128; other values unsupported).
- NUM_ROUNDS, 10, last round index emitted.

Ports:
- clk  input  1  single system clock, rising edge.
- resetN  input  1  asynchronous, active-low reset.
- start  input  1  request expansion of keyIn; sampled only when keyInReady=1.
- keyIn  input  128  cipher key; w0 = keyIn[127:96], w3 = keyIn[31:0].
- keyInReady  output  1  high in IDLE only.
- roundKeyOut  output  128  current round key {w4i, w4i+1, w4i+2, w4i+3}.
- roundIdx  output  4  index of roundKeyOut, 0..10.
- keyValid  output  1  roundKeyOut/roundIdx valid.
- keyReady  input  1  downstream accepts when keyValid && keyReady.
- done  output  1  one-cycle pulse on the cycle after round 10 is accepted.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, keyInReady=1, keyValid=0, roundKeyOut=0, roundIdx=0, done=0.
- FSM states: IDLE, EMIT, FINISH.
- IDLE: on start && keyInReady at edge T:
  - load keyIn into the key register, roundIdx=0, go to EMIT.
  - keyValid=1 and keyInReady=0 from T+1.
- EMIT: keyValid=1.
  - While keyReady=0, roundKeyOut and roundIdx hold stable (no bubble, no change).
  - On accept with roundIdx<10: next cycle roundIdx+1 and roundKeyOut = next key; back-to-back accepts give one key per cycle.
  - On accept with roundIdx=10: go to FINISH, keyValid=0.
- FINISH: done=1 for exactly one cycle, then IDLE with keyInReady=1.
  - Earliest restart: a new start may be accepted in the IDLE cycle.
- Round-number drive: the round number presented to the rcon generator is roundIdx+1, valid 1..10. Combinational path; no added latency.
- Next-key arithmetic (all 32-bit XOR, byte0 = MSB):
  - t = SubWord(RotWord(w3)) ^ rcon, where RotWord = {w3[23:0], w3[31:24]}.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
- start while not in IDLE: ignored; keyIn is not sampled.
- keyReady while keyValid=0: ignored.
- resetN low mid-expansion: immediate abort, all outputs to reset values, no done pulse.
- roundIdx never exceeds 10; no wrap.

Optional Feature:
- Macro: AES_KEY_EXP_STORE_EN.
- When defined:
  - an 11-entry x 128-bit round-key bank is written as each key is accepted;
  - adds ports rdAddr (input, 4) and rdKey (output, 128);
  - rdKey = bank[rdAddr] registered, 1-cycle latency;
  - rdAddr>10 returns 0;
  - the bank is not cleared by reset, but contents are valid only after a done pulse. This supports inverse-order reads for decryption.
- When undefined: streaming only, no bank, no extra ports.

Decomposition:
- Shared package holds:
  - BYTE, WORD, KEY_W, ROUNDNUMREPBITS=4 and NUM_ROUNDS constants;
  - FSM state encoding (IDLE/EMIT/FINISH);
  - the 256-entry S-box constant table.
- Sub-module aes_sub_word: combinational 32-bit SubWord built from four S-box lookups.
- The existing round-constant generator is instantiated unchanged.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, keyReady=1:
  - idx0 = keyIn;
  - idx1 = a0fafe1788542cb123a339392a6c7605;
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - 11 consecutive valid cycles, done at T+12.
- Same key with keyReady toggled randomly (stalls of up to 5 cycles): identical 11-key sequence; outputs stable while stalled; no skipped or duplicated indices.
- start pulsed with key 0 during EMIT at idx 4: ignored; sequence completes with the original key.
- resetN asserted at idx 6: keyValid=0 and keyInReady=1 immediately; no done pulse. Restart with key 000102030405060708090a0b0c0d0e0f gives idx10 = 13111d7fe3944a17f307a78b4d2b30c5.
- Back-to-back: a second start accepted in the IDLE cycle after done; round 0 valid the next cycle.
- With AES_KEY_EXP_STORE_EN: after the FIPS-197 run, rdAddr=1 returns a0fafe17…7605 one cycle later, and rdAddr=12 returns 0.

Source files
------------

// File: rtl/aes_key_expansion_pkg.sv
// Shared definitions for the AES-128 key schedule: widths, round count,
// FSM state encoding and the forward S-box table.
package aes_key_expansion_pkg;

  localparam int BYTE            = 8;
  localparam int WORD            = 32;
  localparam int KEY_W           = 128;
  localparam int ROUNDNUMREPBITS = 4;
  localparam int NUM_ROUNDS      = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [BYTE-1:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant generator: maps round number 1..10 to the rcon word
// {rc, 8'h00, 8'h00, 8'h00}; any other round number yields zero.
module aes_rcon_gen (
  input  logic [3:0]  round_num,
  output logic [31:0] rcon
);

  // Lookup of the round constant byte placed in the most significant lane
  always_comb begin
    rcon = 32'h0;
    case (round_num)
      4'd1:    rcon = 32'h0100_0000;
      4'd2:    rcon = 32'h0200_0000;
      4'd3:    rcon = 32'h0400_0000;
      4'd4:    rcon = 32'h0800_0000;
      4'd5:    rcon = 32'h1000_0000;
      4'd6:    rcon = 32'h2000_0000;
      4'd7:    rcon = 32'h4000_0000;
      4'd8:    rcon = 32'h8000_0000;
      4'd9:    rcon = 32'h1b00_0000;
      4'd10:   rcon = 32'h3600_0000;
      default: rcon = 32'h0;
    endcase
  end

endmodule

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four independent S-box byte substitutions.
module aes_sub_word
  import aes_key_expansion_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  // One S-box lookup per byte lane
  always_comb begin
    word_out = {SBOX[word_in[31:24]], SBOX[word_in[23:16]],
                SBOX[word_in[15:8]],  SBOX[word_in[7:0]]};
  end

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule. Loads a cipher key and streams round keys
// 0..10 over a valid/ready handshake, one new key per accepted cycle.
// Optional round-key bank with registered read port: define AES_KEY_EXP_STORE_EN.
module aes_key_expansion #(
  parameter int KEY_W      = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [KEY_W-1:0] keyIn,
  output logic             keyInReady,
  output logic [KEY_W-1:0] roundKeyOut,
  output logic [3:0]       roundIdx,
  output logic             keyValid,
  input  logic             keyReady,
  output logic             done
`ifdef AES_KEY_EXP_STORE_EN
  ,
  input  logic [3:0]       rdAddr,
  output logic [KEY_W-1:0] rdKey
`endif
);

  import aes_key_expansion_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  state_t           state, state_next;
  logic [KEY_W-1:0] key_q;
  logic [3:0]       idx_q;
  logic [3:0]       round_num;
  logic [31:0]      rcon, rot_w3, sub_w3, t_word;
  logic [31:0]      w0, w1, w2, w3, n0, n1, n2, n3;
  logic             accept;

  assign accept = keyValid && keyReady;

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = EMIT;
      EMIT:    if (keyReady && idx_q == LAST_IDX) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state
  always_comb begin
    keyInReady = (state == IDLE);
    keyValid   = (state == EMIT);
    done       = (state == FINISH);
  end

  // The rcon for the key being derived belongs to round idx+1; held at the
  // last round once idx reaches it so the generator never sees 11.
  assign round_num = (idx_q == LAST_IDX) ? LAST_IDX : idx_q + 4'd1;

  aes_rcon_gen u_rcon (
    .round_num (round_num),
    .rcon      (rcon)
  );

  assign w0     = key_q[127:96];
  assign w1     = key_q[95:64];
  assign w2     = key_q[63:32];
  assign w3     = key_q[31:0];
  assign rot_w3 = {w3[23:0], w3[31:24]};

  aes_sub_word u_sub_word (
    .word_in  (rot_w3),
    .word_out (sub_w3)
  );

  assign t_word = sub_w3 ^ rcon;
  assign n0     = w0 ^ t_word;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;

  // Key and index register: load on start, advance one round per accept
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_q <= '0;
      idx_q <= '0;
    end else if (start && keyInReady) begin
      key_q <= keyIn;
      idx_q <= '0;
    end else if (accept && idx_q != LAST_IDX) begin
      key_q <= {n0, n1, n2, n3};
      idx_q <= idx_q + 4'd1;
    end
  end

  assign roundKeyOut = key_q;
  assign roundIdx    = idx_q;

`ifdef AES_KEY_EXP_STORE_EN
  logic [KEY_W-1:0] bank [0:10];

  // Capture every accepted round key; contents survive reset
  always_ff @(posedge clk) begin
    if (accept) bank[idx_q] <= key_q;
  end

  // Registered read; out-of-range addresses read as zero
  always_ff @(posedge clk) begin
    if (rdAddr <= LAST_IDX) rdKey <= bank[rdAddr];
    else                    rdKey <= '0;
  end
`endif

endmodule

// File: tb/tb_aes_key_expansion.sv
// Scoreboard bench for aes_key_expansion: expected round keys are queued at
// start and compared whenever the DUT presents a valid key.
module tb_aes_key_expansion;

  logic         clk = 1'b0;
  logic         resetN;
  logic         start;
  logic [127:0] keyIn;
  logic         keyInReady;
  logic [127:0] roundKeyOut;
  logic [3:0]   roundIdx;
  logic         keyValid;
  logic         keyReady;
  logic         done;
`ifdef AES_KEY_EXP_STORE_EN
  logic [3:0]   rdAddr;
  logic [127:0] rdKey;
`endif

  aes_key_expansion dut (
    .clk         (clk),
    .resetN      (resetN),
    .start       (start),
    .keyIn       (keyIn),
    .keyInReady  (keyInReady),
    .roundKeyOut (roundKeyOut),
    .roundIdx    (roundIdx),
    .keyValid    (keyValid),
    .keyReady    (keyReady),
    .done        (done)
`ifdef AES_KEY_EXP_STORE_EN
    ,
    .rdAddr      (rdAddr),
    .rdKey       (rdKey)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    bit           care;
  } exp_t;

  exp_t sb [$];

  int checks_total  = 0;
  int checks_passed = 0;

  logic [127:0] fips [0:10];
  logic [127:0] key2      = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] key2_last = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks_total++;
    if (obs === expv) checks_passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  task automatic push_schedule(input int set);
    exp_t e;
    for (int i = 0; i <= 10; i++) begin
      e.idx = 4'(i);
      if (set == 0) begin
        e.key  = fips[i];
        e.care = 1'b1;
      end else begin
        e.key  = (i == 0) ? key2 : ((i == 10) ? key2_last : 128'h0);
        e.care = (i == 0) || (i == 10);
      end
      sb.push_back(e);
    end
  endtask

  // Compare every presented key against the head of the scoreboard
  always @(negedge clk) begin
    if (resetN === 1'b1 && keyValid === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 128'd0, 128'd1);
      end else begin
        check("round_idx", {124'h0, roundIdx}, {124'h0, sb[0].idx});
        if (sb[0].care) check("round_key", roundKeyOut, sb[0].key);
        if (keyReady) void'(sb.pop_front());
      end
    end
  end

  task automatic expand(input logic [127:0] k, input int set, input bit rnd,
                        input int abort_idx, input int ign_idx);
    int  n;
    int  stall;
    bit  seen_done;
    bit  ign_sent;
    seen_done = 0;
    ign_sent  = 0;
    stall     = 0;
    keyIn     = k;
    start     = 1'b1;
    push_schedule(set);
    @(posedge clk); #1;
    start = 1'b0;
    keyIn = '0;
    for (n = 1; n <= 300; n++) begin
      start = 1'b0;
      if (!rnd) keyReady = 1'b1;
      else if (stall > 0) begin
        keyReady = 1'b0;
        stall--;
      end else if ($urandom_range(0, 2) == 0) begin
        keyReady = 1'b0;
        stall = int'($urandom_range(1, 5)) - 1;
      end else keyReady = 1'b1;
      @(negedge clk);
      if (n == 1) begin
        check("valid_after_start", {127'h0, keyValid}, 128'd1);
        check("inready_low_busy", {127'h0, keyInReady}, 128'd0);
      end
      if (abort_idx >= 0 && keyValid && roundIdx == 4'(abort_idx)) begin
        resetN = 1'b0;
        sb.delete();
        #1;
        check("abort_valid", {127'h0, keyValid}, 128'd0);
        check("abort_inready", {127'h0, keyInReady}, 128'd1);
        check("abort_key", roundKeyOut, 128'h0);
        check("abort_idx", {124'h0, roundIdx}, 128'h0);
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check("abort_no_done", {127'h0, done}, 128'd0);
        end
        @(posedge clk); #1;
        resetN = 1'b1;
        return;
      end
      if (ign_idx >= 0 && !ign_sent && keyValid && roundIdx == 4'(ign_idx)) begin
        start    = 1'b1;
        keyIn    = '0;
        ign_sent = 1;
      end
      if (done) begin
        seen_done = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!seen_done) check("done_timeout", 128'd0, 128'd1);
    else if (!rnd) check("done_latency", 128'(n), 128'd12);
    @(posedge clk); #1;
    check("done_one_cycle", {127'h0, done}, 128'd0);
    check("inready_idle", {127'h0, keyInReady}, 128'd1);
    check("sb_empty", 128'(sb.size()), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    fips = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
             128'ha0fafe1788542cb123a339392a6c7605,
             128'hf2c295f27a96b9435935807a7359f67f,
             128'h3d80477d4716fe3e1e237e446d7a883b,
             128'hef44a541a8525b7fb671253bdb0bad00,
             128'hd4d1c6f87c839d87caf2b8bc11f915bc,
             128'h6d88a37a110b3efddbf98641ca0093fd,
             128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
             128'head27321b58dbad2312bf5607f8d292f,
             128'hac7766f319fadc2128d12941575c006e,
             128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    resetN   = 1'b0;
    start    = 1'b0;
    keyIn    = '0;
    keyReady = 1'b0;
`ifdef AES_KEY_EXP_STORE_EN
    rdAddr   = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_inready", {127'h0, keyInReady}, 128'd1);
    check("rst_valid", {127'h0, keyValid}, 128'd0);
    check("rst_key", roundKeyOut, 128'h0);
    check("rst_idx", {124'h0, roundIdx}, 128'h0);
    check("rst_done", {127'h0, done}, 128'd0);
    resetN = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 key, always ready
    expand(fips[0], 0, 1'b0, -1, -1);

`ifdef AES_KEY_EXP_STORE_EN
    rdAddr = 4'd1;
    @(posedge clk); #1;
    check("bank_rd1", rdKey, fips[1]);
    rdAddr = 4'd12;
    @(posedge clk); #1;
    check("bank_rd12", rdKey, 128'h0);
    rdAddr = 4'd10;
    @(posedge clk); #1;
    check("bank_rd10", rdKey, fips[10]);
`endif

    // Same key with random back-pressure
    expand(fips[0], 0, 1'b1, -1, -1);
    // Stray start with key 0 at round 4 must be ignored
    expand(fips[0], 0, 1'b0, -1, 4);
    // Reset at round 6 aborts; restart with the second key
    expand(fips[0], 0, 1'b0, 6, -1);
    expand(key2, 1, 1'b0, -1, -1);
    // Back-to-back restart in the IDLE cycle right after done
    expand(fips[0], 0, 1'b0, -1, -1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
